// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands
// are ready, snoops ALU/LSB broadcasts, issues one ready op per cycle.
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_op,
  input  logic [31:0]      in_v1,
  input  logic [31:0]      in_v2,
  input  logic [TAG_W-1:0] in_q1,
  input  logic [TAG_W-1:0] in_q2,
  input  logic [TAG_W-1:0] in_des,
  input  logic             in_is_branch,
  output logic             full,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_value,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_value,
  output logic [31:0]      value_1,
  output logic [31:0]      value_2,
  output logic [4:0]       op,
  output logic [TAG_W-1:0] des,
  output logic             is_branch
);

  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic             busy;
    logic [4:0]       op;
    logic [31:0]      v1;
    logic [TAG_W-1:0] q1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] q2;
    logic [TAG_W-1:0] des;
    logic             br;
  } slot_t;

  slot_t slot_q [ENTRIES];
  slot_t slot_d [ENTRIES];

  logic          free_ok;
  logic [IW-1:0] free_idx;
  logic          iss_ok;
  logic [IW-1:0] iss_idx;

  logic [31:0]      nx_v1;
  logic [31:0]      nx_v2;
  logic [4:0]       nx_op;
  logic [TAG_W-1:0] nx_des;
  logic             nx_br;

  // ALU bus checked first so it wins a same-tag conflict
  function automatic logic [TAG_W+31:0] wake(
    input logic [TAG_W-1:0] q,
    input logic [31:0]      v,
    input logic [TAG_W-1:0] at,
    input logic [31:0]      av,
    input logic [TAG_W-1:0] lt,
    input logic [31:0]      lv
  );
    logic [TAG_W+31:0] r;
    r = {q, v};
    if (q != '0 && q == at)
      r = {{TAG_W{1'b0}}, av};
    else if (q != '0 && q == lt)
      r = {{TAG_W{1'b0}}, lv};
    return r;
  endfunction

  always_comb begin
    full     = 1'b1;
    free_ok  = 1'b0;
    free_idx = '0;
    iss_ok   = 1'b0;
    iss_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!slot_q[i].busy) begin
        full     = 1'b0;
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (slot_q[i].busy && slot_q[i].q1 == '0 &&
          slot_q[i].q2 == '0) begin
        iss_ok  = 1'b1;
        iss_idx = IW'(i);
      end
    end
  end

  always_comb begin
    nx_v1  = '0;
    nx_v2  = '0;
    nx_op  = '0;
    nx_des = '0;
    nx_br  = 1'b0;
    if (iss_ok) begin
      nx_v1  = slot_q[iss_idx].v1;
      nx_v2  = slot_q[iss_idx].v2;
      nx_op  = slot_q[iss_idx].op;
      nx_des = slot_q[iss_idx].des;
      nx_br  = slot_q[iss_idx].br;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].busy) begin
        {slot_d[i].q1, slot_d[i].v1} = wake(
          slot_q[i].q1, slot_q[i].v1, cdb_alu_tag,
          cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
        {slot_d[i].q2, slot_d[i].v2} = wake(
          slot_q[i].q2, slot_q[i].v2, cdb_alu_tag,
          cdb_alu_value, cdb_lsb_tag, cdb_lsb_value);
      end
    end
    if (iss_ok)
      slot_d[iss_idx].busy = 1'b0;
    // free_idx is never the issuing slot: both use start-of-cycle busy
    if (in_valid && free_ok) begin
      slot_d[free_idx].busy = 1'b1;
      slot_d[free_idx].op   = in_op;
      slot_d[free_idx].des  = in_des;
      slot_d[free_idx].br   = in_is_branch;
      {slot_d[free_idx].q1, slot_d[free_idx].v1} = wake(
        in_q1, in_v1, cdb_alu_tag, cdb_alu_value,
        cdb_lsb_tag, cdb_lsb_value);
      {slot_d[free_idx].q2, slot_d[free_idx].v2} = wake(
        in_q2, in_v2, cdb_alu_tag, cdb_alu_value,
        cdb_lsb_tag, cdb_lsb_value);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < ENTRIES; i++)
        slot_q[i] <= '0;
      value_1   <= '0;
      value_2   <= '0;
      op        <= '0;
      des       <= '0;
      is_branch <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++)
        slot_q[i] <= slot_d[i];
      value_1   <= nx_v1;
      value_2   <= nx_v2;
      op        <= nx_op;
      des       <= nx_des;
      is_branch <= nx_br;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: stimulus pushes expected issues,
// a negedge monitor pops and compares whenever des is nonzero.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_op;
  logic [31:0] in_v1;
  logic [31:0] in_v2;
  logic [2:0]  in_q1;
  logic [2:0]  in_q2;
  logic [2:0]  in_des;
  logic        in_is_branch;
  logic        full;
  logic [2:0]  cdb_alu_tag;
  logic [31:0] cdb_alu_value;
  logic [2:0]  cdb_lsb_tag;
  logic [31:0] cdb_lsb_value;
  logic [31:0] value_1;
  logic [31:0] value_2;
  logic [4:0]  op;
  logic [2:0]  des;
  logic        is_branch;

  alu_rs #(.ENTRIES(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2),
    .in_q1(in_q1), .in_q2(in_q2),
    .in_des(in_des), .in_is_branch(in_is_branch),
    .full(full),
    .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .value_1(value_1), .value_2(value_2), .op(op),
    .des(des), .is_branch(is_branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  op;
    logic [2:0]  des;
    logic        br;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic push(input logic [31:0] v1, input logic [31:0] v2,
                      input logic [4:0] o, input logic [2:0] d,
                      input logic br, input int c);
    exp_t e;
    e.v1 = v1; e.v2 = v2; e.op = o; e.des = d; e.br = br; e.cyc = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && des !== 3'd0) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_issue: got des=%0d expected none",
                 des);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_des", 32'(des), 32'(e.des));
        chk("issue_v1", value_1, e.v1);
        chk("issue_v2", value_2, e.v2);
        chk("issue_op", 32'(op), 32'(e.op));
        chk("issue_br", 32'(is_branch), 32'(e.br));
        chk("issue_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic idle;
    in_valid      = 1'b0;
    cdb_alu_tag   = '0;
    cdb_alu_value = '0;
    cdb_lsb_tag   = '0;
    cdb_lsb_value = '0;
  endtask

  task automatic disp(input logic [4:0] o, input logic [31:0] v1,
                      input logic [2:0] q1, input logic [31:0] v2,
                      input logic [2:0] q2, input logic [2:0] d,
                      input logic br);
    in_valid     = 1'b1;
    in_op        = o;
    in_v1        = v1;
    in_q1        = q1;
    in_v2        = v2;
    in_q2        = q2;
    in_des       = d;
    in_is_branch = br;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    disp(5'd1, 32'd11, 3'd0, 32'd12, 3'd0, 3'd7, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    idle();
    chk("reset_des", 32'(des), 32'd0);
    chk("reset_value_1", value_1, 32'd0);
    chk("reset_full", 32'(full), 32'd0);

    // ready dispatch
    disp(5'd0, 32'd5, 3'd0, 32'd7, 3'd0, 3'd3, 1'b0);
    push(32'd5, 32'd7, 5'd0, 3'd3, 1'b0, cyc + 2);
    step();
    idle();
    repeat (3) step();

    // wakeup one cycle after dispatch
    disp(5'd3, 32'hDEAD, 3'd2, 32'd9, 3'd0, 3'd4, 1'b0);
    step();
    idle();
    cdb_alu_tag   = 3'd2;
    cdb_alu_value = 32'h100;
    push(32'h100, 32'd9, 5'd3, 3'd4, 1'b0, cyc + 2);
    step();
    idle();
    repeat (3) step();

    // broadcast in the dispatch cycle
    disp(5'd4, 32'hBEEF, 3'd2, 32'd9, 3'd0, 3'd4, 1'b1);
    cdb_alu_tag   = 3'd2;
    cdb_alu_value = 32'h100;
    push(32'h100, 32'd9, 5'd4, 3'd4, 1'b1, cyc + 2);
    step();
    idle();
    repeat (3) step();

    // fill all slots, drop a fifth, then wake all from LSB bus
    for (int i = 1; i <= 4; i++) begin
      disp(5'd6, 32'hDEAD, 3'd6, 32'(i * 16), 3'd0, 3'(i), 1'b0);
      step();
    end
    idle();
    chk("full_set", 32'(full), 32'd1);
    disp(5'd7, 32'd1, 3'd0, 32'd2, 3'd0, 3'd5, 1'b0);
    step();
    idle();
    chk("full_hold", 32'(full), 32'd1);
    cdb_lsb_tag   = 3'd6;
    cdb_lsb_value = 32'h55;
    for (int i = 1; i <= 4; i++)
      push(32'h55, 32'(i * 16), 5'd6, 3'(i), 1'b0, cyc + 1 + i);
    step();
    idle();
    step();
    chk("full_drop", 32'(full), 32'd0);
    repeat (5) step();

    // dual-bus conflict: ALU value wins
    disp(5'd8, 32'd0, 3'd5, 32'd3, 3'd0, 3'd6, 1'b0);
    step();
    idle();
    cdb_alu_tag   = 3'd5;
    cdb_alu_value = 32'hA;
    cdb_lsb_tag   = 3'd5;
    cdb_lsb_value = 32'hB;
    push(32'hA, 32'd3, 5'd8, 3'd6, 1'b0, cyc + 2);
    step();
    idle();
    repeat (3) step();

    // flush with three busy slots, one about to issue
    disp(5'd9, 32'd1, 3'd7, 32'd1, 3'd0, 3'd1, 1'b0);
    step();
    disp(5'd9, 32'd2, 3'd7, 32'd2, 3'd0, 3'd2, 1'b0);
    step();
    disp(5'd10, 32'd3, 3'd0, 32'd4, 3'd0, 3'd3, 1'b0);
    step();
    flush = 1'b1;
    disp(5'd11, 32'd5, 3'd0, 32'd6, 3'd0, 3'd5, 1'b0);
    step();
    flush = 1'b0;
    idle();
    chk("flush_des", 32'(des), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    cdb_alu_tag   = 3'd7;
    cdb_alu_value = 32'h77;
    step();
    idle();
    repeat (5) step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
